// File: rtl/sm_mac_if.sv
// Stream-side bundle of the sign-magnitude MAC: operand pairs in, saturated result out.
interface sm_mac_if #(
  parameter int N = 8
);
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] w;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         ovf;
  logic         busy;

  modport master (
    output start, in_valid, a, w, out_ready,
    input  in_ready, out_valid, out, ovf, busy
  );

  modport slave (
    input  start, in_valid, a, w, out_ready,
    output in_ready, out_valid, out, ovf, busy
  );
endinterface

// File: rtl/sm_mac_unit.sv
// Sequential sign-magnitude MAC: LEN products (N-1 fractional bits) summed in a wide
// two's-complement accumulator, returned as a saturated sign-magnitude dot product.
module sm_mac_unit #(
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int ROUND = 0
) (
  input  logic      clk,
  input  logic      rst,
  sm_mac_if.slave   bus
);

  localparam int ACC_W = N + $clog2(LEN) + 1;
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PW    = 2 * N - 2;
  localparam logic [PW-1:0]    RND     = (ROUND != 0) ? (PW'(1) << (N - 2)) : '0;
  localparam logic [ACC_W-1:0] MAX_MAG = ACC_W'((1 << (N - 1)) - 1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [N-2:0]              prod_mag_q, prod_mag_d;
  logic                      prod_sign_q, prod_sign_d;
  logic                      prod_vld_q;
  logic [N-1:0]              out_q, out_d;
  logic                      ovf_q, ovf_d;

  logic                      in_ready;
  logic                      xfer;
  logic                      clear;
  logic [PW-1:0]             prod_full;
  logic signed [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]          acc_abs;
  logic                      sat;

  assign xfer  = bus.in_valid && in_ready;
  assign clear = (state_q == IDLE) && bus.start;

  // Product stage: rounding constant is added before dropping the N-1 fractional bits.
  assign prod_full   = PW'(bus.a[N-2:0]) * PW'(bus.w[N-2:0]) + RND;
  assign prod_mag_d  = prod_full[PW-1:N-1];
  assign prod_sign_d = (bus.a[N-1] ^ bus.w[N-1]) && (prod_mag_d != '0);

  assign addend = prod_sign_q ? -$signed({{(ACC_W-N+1){1'b0}}, prod_mag_q})
                              :  $signed({{(ACC_W-N+1){1'b0}}, prod_mag_q});

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (prod_vld_q) acc_d = acc_q + addend;
      if (xfer)       cnt_d = cnt_q + 1'b1;
    end
  end

  // The result is formed from the accumulator value that lands on the DRAIN->DONE edge.
  always_comb begin
    acc_abs = acc_d[ACC_W-1] ? -acc_d : acc_d;
    sat     = acc_abs > MAX_MAG;
    out_d   = {acc_d[ACC_W-1], sat ? MAX_MAG[N-2:0] : acc_abs[N-2:0]};
    ovf_d   = sat;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = ACC;
      ACC:   if (xfer && cnt_q == CNT_W'(LEN - 1)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == ACC);
    bus.in_ready  = in_ready;
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out       = out_q;
    bus.ovf       = ovf_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_mag_q  <= '0;
      prod_sign_q <= 1'b0;
      prod_vld_q  <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      prod_vld_q <= xfer;
      if (xfer) begin
        prod_mag_q  <= prod_mag_d;
        prod_sign_q <= prod_sign_d;
      end
      if (state_q == DRAIN) begin
        out_q <= out_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule
